mips_dmem_bus: RTL and testbench
================================

# mips_dmem_bus

Data-side memory responder for the single-cycle MIPS core. It answers the core's data port (address, write data, write enable, read data) with a word-addressed RAM plus a memory-mapped I/O page containing GPIO, an optional compare timer and a sticky bus-error register. Reads are combinational, so the single-cycle core receives data in the same cycle it issues the address. Writes commit on the rising clock edge.

## Interface
- RAM_WORDS, 64, RAM depth in 32-bit words; power of two, 16..4096.
- GPIO_W, 8, GPIO output and input width; 1..32.

- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- memwrite  in  1  write strobe; write is committed at the rising edge of clk.
- aluout  in  32  byte address from the core.
- writedata  in  32  store data.
- readdata  out  32  combinational load data.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  registered outputs; reset value 0.
- timer_irq  out  1  timer pending flag; reset value 0.
- bus_err  out  1  sticky error flag; reset value 0.

## Operation
- Address map (word accesses only):
  - RAM: 0x0000_0000 .. RAM_WORDS*4-1.
  - GPIO_OUT (RW): 0xFFFF_0000.
  - GPIO_IN (RO): 0xFFFF_0004.
  - TCOUNT (RW): 0xFFFF_0010.
  - TCMP (RW): 0xFFFF_0014.
  - TCTRL (RW): 0xFFFF_0018. bit0 = EN, bit1 = PEND (write 1 to clear), bit2 = AUTORELOAD.
  - ERR (RW): 0xFFFF_001C. bit0 = bus_err (write 1 to clear).
- An access is an error if it is unaligned (aluout[1:0] != 0), unmapped, or a write to GPIO_IN. Error response:
  - readdata = 0.
  - The write is dropped.
  - bus_err sets at the next edge.
- Error qualification: a read counts as an access only when aluout decodes to a load. The block has no read strobe, so bus_err is set on writes only. Bad-address reads return 0 silently.
- Unused register bits read 0. GPIO_OUT and GPIO_IN are zero-extended to 32 bits.
- RAM contents are not reset and are undefined after power-up. Other state is reset to 0 asynchronously.
- Read of an address in the same cycle it is written returns the old value. The new value is visible from the next cycle.
- GPIO_IN passes through a 2-flop synchronizer. A change on gpio_in is visible in readdata 2 edges later.
- Timer, when EN = 1:
  - TCOUNT increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - When TCOUNT == TCMP, PEND sets at the next edge.
  - On a match, TCOUNT loads 0 if AUTORELOAD = 1; otherwise it keeps incrementing.
  - With EN = 0, TCOUNT holds and no match is evaluated.
- timer_irq = PEND.
- Simultaneous events:
  - A software write to TCOUNT overrides both increment and reload. The match is still evaluated on the pre-write value.
  - PEND set and a W1C of PEND in the same cycle: set wins.
  - bus_err set and an ERR W1C in the same cycle: set wins.
- Reset asserted mid-operation clears all registers, timer and flags immediately. RAM is untouched.

## Timing
- Load latency is 0 cycles (combinational from aluout).
- Store latency is 1 edge for RAM and all registers.
- gpio_out, timer_irq and bus_err are driven directly from flops.
- gpio_in to readdata latency is 2 edges.
- Timer match to timer_irq latency is 1 edge.

## Configuration
- DMEM_TIMER_EN defined: TCOUNT, TCMP and TCTRL are implemented as described.
- DMEM_TIMER_EN undefined:
  - The timer is not built, and timer_irq is tied to 0.
  - Addresses 0xFFFF_0010..0x18 decode as unmapped: reads return 0 and writes set bus_err.

## Structure
- Shared package mips_pkg holds:
  - MMIO base 0xFFFF_0000 and the register offset constants.
  - TCTRL bit indices (EN, PEND, AUTORELOAD).
  - An enum for the address-decode target (RAM, GPIO_OUT, GPIO_IN, TCOUNT, TCMP, TCTRL, ERR, NONE).
- Sub-module dmem_timer contains TCOUNT, TCMP and TCTRL with its own write-enable/data inputs and irq output. It is instantiated only under DMEM_TIMER_EN.

## Test plan
- Reset then RAM access: write 0xDEAD_BEEF to 0x0000_0010, read back 0x0000_0010 -> 0xDEAD_BEEF. A same-cycle read during the write returns the prior value.
- Write 0xA5 to GPIO_OUT -> gpio_out = 0xA5 after 1 edge. Drive gpio_in = 0x3C -> GPIO_IN reads 0x3C after 2 edges.
- Timer one-shot: TCMP = 5, TCTRL = 1 -> timer_irq rises on the edge after TCOUNT == 5. Then write TCTRL = 0x3 -> PEND clears and EN stays 1.
- Timer autoreload: TCMP = 3, TCTRL = 0x5 -> TCOUNT sequence 0,1,2,3,0,1,… and PEND sets once per period. A W1C of PEND in the same cycle as a match leaves PEND = 1.
- Errors:
  - Write to 0x0000_0002 (unaligned) -> no RAM change, bus_err = 1.
  - Write to 0xFFFF_0004 -> bus_err stays 1.
  - Write ERR = 1 -> bus_err = 0.
  - With DMEM_TIMER_EN undefined, a write to TCMP -> bus_err = 1 and timer_irq stays 0.
- Assert reset_n low mid-count (TCOUNT = 0x20) -> TCOUNT, gpio_out, timer_irq and bus_err are 0 immediately. A RAM word written before reset reads back unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory responder: MMIO map,
// TCTRL bit positions and the address-decode helper.
package mips_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'hFFFF_0000;
    localparam logic [7:0]  OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0]  OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0]  OFF_TCOUNT   = 8'h10;
    localparam logic [7:0]  OFF_TCMP     = 8'h14;
    localparam logic [7:0]  OFF_TCTRL    = 8'h18;
    localparam logic [7:0]  OFF_ERR      = 8'h1C;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_PEND = 1;
    localparam int TCTRL_AUTO = 2;

    typedef enum logic [2:0] {
        TGT_RAM, TGT_GPIO_OUT, TGT_GPIO_IN, TGT_TCOUNT,
        TGT_TCMP, TGT_TCTRL, TGT_ERR, TGT_NONE
    } dmem_tgt_e;

    // Unaligned addresses never hit anything; timer offsets vanish when it is not built.
    function automatic dmem_tgt_e dmem_decode(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic        timer_en);
        dmem_tgt_e t;
        t = TGT_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr < ram_bytes) begin
                t = TGT_RAM;
            end else if (addr[31:8] == MMIO_BASE[31:8]) begin
                case (addr[7:0])
                    OFF_GPIO_OUT: t = TGT_GPIO_OUT;
                    OFF_GPIO_IN:  t = TGT_GPIO_IN;
                    OFF_TCOUNT:   t = timer_en ? TGT_TCOUNT : TGT_NONE;
                    OFF_TCMP:     t = timer_en ? TGT_TCMP   : TGT_NONE;
                    OFF_TCTRL:    t = timer_en ? TGT_TCTRL  : TGT_NONE;
                    OFF_ERR:      t = TGT_ERR;
                    default:      t = TGT_NONE;
                endcase
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/mips_dmem_bus_if.sv
// Core data-port bundle: address, store data/strobe and combinational load data.
interface mips_dmem_bus_if;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, aluout, writedata, input readdata);
    modport slave  (input memwrite, aluout, writedata, output readdata);
endinterface

// File: rtl/dmem_timer.sv
// Compare timer: TCOUNT/TCMP/TCTRL with one-shot or auto-reload match and
// a sticky PEND flag driving irq_o.
module dmem_timer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we_count_i,
    input  logic        we_cmp_i,
    input  logic        we_ctrl_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tcount_o,
    output logic [31:0] tcmp_o,
    output logic [2:0]  tctrl_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d, cmp_q, cmp_d;
    logic        en_q, en_d, auto_q, auto_d, pend_q, pend_d;
    logic        match;

    assign match = en_q && (count_q == cmp_q);

    // A software write to TCOUNT beats increment/reload; the match above
    // still sees the pre-write count. A match beats a PEND clear.
    always_comb begin
        count_d = count_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        auto_d  = auto_q;
        pend_d  = pend_q;
        if (en_q)
            count_d = (match && auto_q) ? 32'd0 : count_q + 32'd1;
        if (we_count_i)
            count_d = wdata_i;
        if (we_cmp_i)
            cmp_d = wdata_i;
        if (we_ctrl_i) begin
            en_d   = wdata_i[TCTRL_EN];
            auto_d = wdata_i[TCTRL_AUTO];
            if (wdata_i[TCTRL_PEND])
                pend_d = 1'b0;
        end
        if (match)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            cmp_q   <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        tctrl_o             = '0;
        tctrl_o[TCTRL_EN]   = en_q;
        tctrl_o[TCTRL_PEND] = pend_q;
        tctrl_o[TCTRL_AUTO] = auto_q;
    end

    assign tcount_o = count_q;
    assign tcmp_o   = cmp_q;
    assign irq_o    = pend_q;

endmodule

// File: rtl/mips_dmem_bus.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus MMIO page
// (GPIO, sticky ERR, compare timer only when DMEM_TIMER_EN is defined).
module mips_dmem_bus
    import mips_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    mips_dmem_bus_if.slave    bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              bus_err
);

    localparam int AW = $clog2(RAM_WORDS);
`ifdef DMEM_TIMER_EN
    localparam logic TIMER_EN = 1'b1;
`else
    localparam logic TIMER_EN = 1'b0;
`endif

    dmem_tgt_e   tgt;
    logic        acc_err, wr_ok;
    logic [AW-1:0] widx;
    logic [31:0] rdata;
    logic [31:0] tcount, tcmp;
    logic [2:0]  tctrl;

    logic [31:0]       mem_q [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_q, gpio_d, sync1_q, sync2_q;
    logic              err_q, err_d;

    assign tgt     = dmem_decode(bus.aluout, 32'(RAM_WORDS * 4), TIMER_EN);
    assign acc_err = (tgt == TGT_NONE) || (tgt == TGT_GPIO_IN && bus.memwrite);
    assign wr_ok   = bus.memwrite && !acc_err;
    assign widx    = bus.aluout[AW+1:2];

    always_ff @(posedge clk) begin
        if (wr_ok && tgt == TGT_RAM)
            mem_q[widx] <= bus.writedata;
    end

    // Only stores can flag an error: there is no read strobe to qualify loads.
    always_comb begin
        err_d = err_q;
        if (wr_ok && tgt == TGT_ERR && bus.writedata[0])
            err_d = 1'b0;
        if (bus.memwrite && acc_err)
            err_d = 1'b1;
    end

    assign gpio_d = (wr_ok && tgt == TGT_GPIO_OUT) ? bus.writedata[GPIO_W-1:0] : gpio_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            err_q   <= 1'b0;
        end else begin
            gpio_q  <= gpio_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            err_q   <= err_d;
        end
    end

`ifdef DMEM_TIMER_EN
    dmem_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_count_i (wr_ok && tgt == TGT_TCOUNT),
        .we_cmp_i   (wr_ok && tgt == TGT_TCMP),
        .we_ctrl_i  (wr_ok && tgt == TGT_TCTRL),
        .wdata_i    (bus.writedata),
        .tcount_o   (tcount),
        .tcmp_o     (tcmp),
        .tctrl_o    (tctrl),
        .irq_o      (timer_irq)
    );
`else
    assign tcount    = '0;
    assign tcmp      = '0;
    assign tctrl     = '0;
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (!acc_err) begin
            case (tgt)
                TGT_RAM:      rdata = mem_q[widx];
                TGT_GPIO_OUT: rdata = 32'(gpio_q);
                TGT_GPIO_IN:  rdata = 32'(sync2_q);
                TGT_TCOUNT:   rdata = tcount;
                TGT_TCMP:     rdata = tcmp;
                TGT_TCTRL:    rdata = 32'(tctrl);
                TGT_ERR:      rdata = 32'(err_q);
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.readdata = rdata;
    assign gpio_out     = gpio_q;
    assign bus_err      = err_q;

endmodule

// File: tb/tb_mips_dmem_bus.sv
// Self-checking bench for mips_dmem_bus: vector table with a readdata
// scoreboard, plus hand sequences for synchronizer, timer and mid-run reset.
module tb_mips_dmem_bus;

`ifdef DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] gpio_in, gpio_out;
    logic       timer_irq, bus_err;
    int         tests = 0, fails = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mips_dmem_bus_if bus ();

    mips_dmem_bus #(.RAM_WORDS(64), .GPIO_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] rd;
        logic [7:0]  gpio;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one core cycle at the falling edge; load data is checked 2ns later.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic c, input logic [31:0] e, input string nm);
        logic [31:0] exp;
        @(negedge clk);
        bus.memwrite  = we;
        bus.aluout    = a;
        bus.writedata = wd;
        if (c) sb.push_back(e);
        #2;
        if (c) begin
            exp = sb.pop_front();
            chk(nm, bus.readdata, exp);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic c, input logic [31:0] rd, input logic [7:0] g, input logic e);
        vec_t v;
        v.we = we; v.addr = a; v.wd = wd; v.chk = c; v.rd = rd; v.gpio = g; v.err = e;
        tbl.push_back(v);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.memwrite  = 1'b0;
        bus.aluout    = '0;
        bus.writedata = '0;
        gpio_in       = '0;
        #1;
        chk("reset gpio_out", 32'(gpio_out), 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'h0);
        chk("reset timer_irq", 32'(timer_irq), 32'h0);
        #11 reset_n = 1'b1;

        add(1, 32'h0000_0000, 32'hCAFE_0000, 0, 0, 8'h00, 0);
        add(1, 32'h0000_0010, 32'h1111_1111, 0, 0, 8'h00, 0);
        add(1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h1111_1111, 8'h00, 0);
        add(0, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF, 8'h00, 0);
        add(1, 32'hFFFF_0000, 32'h0000_00A5, 1, 0, 8'h00, 0);
        add(0, 32'hFFFF_0000, 0, 1, 32'h0000_00A5, 8'hA5, 0);
        add(1, 32'h0000_0002, 32'h1234_5678, 1, 0, 8'hA5, 0);
        add(0, 32'h0000_0000, 0, 1, 32'hCAFE_0000, 8'hA5, 1);
        add(1, 32'hFFFF_0004, 32'hFF, 1, 0, 8'hA5, 1);
        add(0, 32'hFFFF_0004, 0, 1, 0, 8'hA5, 1);
        add(1, 32'hFFFF_001C, 32'h1, 1, 32'h1, 8'hA5, 1);
        add(0, 32'hFFFF_001C, 0, 1, 0, 8'hA5, 0);
        add(0, 32'h0000_0100, 0, 1, 0, 8'hA5, 0);
        add(0, 32'hFFFF_0020, 0, 1, 0, 8'hA5, 0);
        add(0, 32'hFFFF_0003, 0, 1, 0, 8'hA5, 0);
        add(1, 32'hFFFF_0014, 32'h5, 1, 0, 8'hA5, 0);
        add(0, 32'hFFFF_0014, 0, 1, TIMER ? 32'h5 : 32'h0, 8'hA5, !TIMER);
        add(1, 32'hFFFF_001C, 32'h1, 1, TIMER ? 32'h0 : 32'h1, 8'hA5, !TIMER);
        add(0, 32'hFFFF_0010, 0, 1, 0, 8'hA5, 0);

        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].chk, tbl[i].rd, $sformatf("vec%0d rd", i));
            chk($sformatf("vec%0d gpio_out", i), 32'(gpio_out), 32'(tbl[i].gpio));
            chk($sformatf("vec%0d bus_err", i), 32'(bus_err), 32'(tbl[i].err));
        end
        chk("timer_irq idle", 32'(timer_irq), 32'h0);

        // gpio_in through the 2-flop synchronizer
        @(negedge clk);
        gpio_in = 8'h3C; bus.memwrite = 1'b0; bus.aluout = 32'hFFFF_0004;
        #2 chk("gpio_in 0 edges", bus.readdata, 32'h0);
        @(negedge clk); #2 chk("gpio_in 1 edge", bus.readdata, 32'h0);
        @(negedge clk); #2 chk("gpio_in 2 edges", bus.readdata, 32'h3C);

`ifdef DMEM_TIMER_EN
        // one-shot: PEND rises on the edge after TCOUNT == TCMP
        step(1, 32'hFFFF_0010, 32'h0, 0, 0, "");
        step(1, 32'hFFFF_0014, 32'h5, 0, 0, "");
        step(1, 32'hFFFF_0018, 32'h1, 0, 0, "");
        for (int i = 0; i < 8; i++) begin
            step(0, 32'hFFFF_0010, 0, 1, 32'(i), $sformatf("oneshot count%0d", i));
            chk($sformatf("oneshot irq%0d", i), 32'(timer_irq), 32'(i >= 6));
        end
        step(1, 32'hFFFF_0018, 32'h3, 1, 32'h3, "tctrl before w1c");
        step(0, 32'hFFFF_0018, 0, 1, 32'h1, "tctrl after w1c");
        chk("oneshot irq cleared", 32'(timer_irq), 32'h0);

        // auto-reload period 4; W1C on the matching cycle loses to the set
        step(1, 32'hFFFF_0018, 32'h0, 0, 0, "");
        step(1, 32'hFFFF_0010, 32'h0, 0, 0, "");
        step(1, 32'hFFFF_0014, 32'h3, 0, 0, "");
        step(1, 32'hFFFF_0018, 32'h5, 0, 0, "");
        for (int k = 0; k < 8; k++) begin
            if (k == 7)
                step(1, 32'hFFFF_0018, 32'h7, 1, 32'h7, "reload w1c cycle");
            else
                step(0, 32'hFFFF_0010, 0, 1, 32'(k % 4), $sformatf("reload count%0d", k));
            chk($sformatf("reload irq%0d", k), 32'(timer_irq), 32'(k >= 4));
        end
        step(0, 32'hFFFF_0018, 0, 1, 32'h7, "pend set wins");
        step(0, 32'hFFFF_0010, 0, 1, 32'h1, "reload count after w1c");

        step(1, 32'hFFFF_0018, 32'h0, 0, 0, "");
        step(1, 32'hFFFF_0010, 32'h20, 0, 0, "");
`endif

        // mid-run reset clears registers immediately, RAM survives
        step(1, 32'hFFFF_0000, 32'h5A, 0, 0, "");
        step(1, 32'h0000_0006, 32'h0, 0, 0, "");
        step(0, 32'hFFFF_0010, 0, 1, TIMER ? 32'h20 : 32'h0, "tcount before reset");
        chk("gpio before reset", 32'(gpio_out), 32'h5A);
        chk("err before reset", 32'(bus_err), 32'h1);
        chk("irq before reset", 32'(timer_irq), 32'(TIMER));
        #1 reset_n = 1'b0;
        #1;
        chk("async reset gpio_out", 32'(gpio_out), 32'h0);
        chk("async reset bus_err", 32'(bus_err), 32'h0);
        chk("async reset timer_irq", 32'(timer_irq), 32'h0);
        chk("async reset tcount", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF, "ram after reset");
        step(0, 32'h0000_0000, 0, 1, 32'hCAFE_0000, "ram0 after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
